// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch with an in-order response queue to Decode.
// Optional IFQ_BYPASS_EN forwards a response straight to Decode when the queue is empty and Decode is ready.
module ifetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  inst_valid_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] inst_pc_o,
    input  logic                  inst_ready_i
);
    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW:0]     DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_fetch_pc;

    // Instruction queue: pointers carry one extra wrap bit so full and empty differ.
    logic [DATA_WIDTH-1:0] r_q_data [DEPTH];
    logic [DATA_WIDTH-1:0] r_q_pc   [DEPTH];
    logic [CW-1:0]         r_q_wptr;
    logic [CW-1:0]         r_q_rptr;

    // Issue addresses of outstanding requests, consumed one per response (kept or dropped).
    logic [DATA_WIDTH-1:0] r_a_pc   [DEPTH];
    logic [CW-1:0]         r_a_wptr;
    logic [CW-1:0]         r_a_rptr;

    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_discard;

    logic [CW-1:0]         w_q_count;
    logic                  w_q_empty;
    logic                  w_q_full;
    logic [CW:0]           w_credit_used;
    logic                  w_issue;
    logic                  w_resp_live;
    logic                  w_resp_drop;
    logic                  w_bypass;
    logic                  w_pop;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_resp_pc;
    logic [DATA_WIDTH-1:0] w_fetch_next;

    assign w_q_count     = r_q_wptr - r_q_rptr;
    assign w_q_empty     = (w_q_count == '0);
    assign w_q_full      = (w_q_count == DEPTH_CNT);
    assign w_credit_used = {1'b0, w_q_count} + {1'b0, r_outstanding};

    assign mem_addr_o    = {r_fetch_pc[DATA_WIDTH-1:2], 2'b00};
    assign mem_req_o     = !rst && !redirect_i && (w_credit_used < DEPTH_SUM);
    assign w_issue       = mem_req_o && mem_gnt_i;
    assign w_fetch_next  = r_fetch_pc + DATA_WIDTH'(4);

    assign w_resp_pc     = r_a_pc[r_a_rptr[AW-1:0]];
    assign w_resp_drop   = mem_rvalid_i && (r_discard != '0);
    assign w_resp_live   = mem_rvalid_i && !redirect_i && (r_discard == '0);

`ifdef IFQ_BYPASS_EN
    assign w_bypass      = !rst && w_resp_live && w_q_empty && inst_ready_i;
`else
    assign w_bypass      = 1'b0;
`endif

    assign inst_valid_o  = !rst && ((!w_q_empty && !redirect_i) || w_bypass);
    assign inst_o        = w_bypass ? mem_rdata_i : r_q_data[r_q_rptr[AW-1:0]];
    assign inst_pc_o     = w_bypass ? w_resp_pc   : r_q_pc[r_q_rptr[AW-1:0]];

    // A pop frees a slot in the same cycle, so a push into a full queue is fine then.
    assign w_pop         = !w_q_empty && !redirect_i && inst_ready_i;
    assign w_push        = w_resp_live && !w_bypass && (!w_q_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_q_wptr      <= '0;
            r_q_rptr      <= '0;
            r_a_wptr      <= '0;
            r_a_rptr      <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            if (redirect_i) begin
                r_fetch_pc <= redirect_pc_i;
                r_q_rptr   <= r_q_wptr;
                r_discard  <= r_outstanding - CW'(mem_rvalid_i);
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= w_fetch_next;
                end
                if (w_pop) begin
                    r_q_rptr <= r_q_rptr + CW'(1);
                end
                if (w_push) begin
                    r_q_wptr <= r_q_wptr + CW'(1);
                end
                if (w_resp_drop) begin
                    r_discard <= r_discard - CW'(1);
                end
            end
            if (w_issue) begin
                r_a_wptr <= r_a_wptr + CW'(1);
            end
            if (mem_rvalid_i) begin
                r_a_rptr <= r_a_rptr + CW'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(mem_rvalid_i);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_q_wptr[AW-1:0]] <= mem_rdata_i;
            r_q_pc[r_q_wptr[AW-1:0]]   <= w_resp_pc;
        end
        if (w_issue) begin
            r_a_pc[r_a_wptr[AW-1:0]] <= mem_addr_o;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: redirect-address table, directed corner sequences, random traffic vs a queue model.
module tb_ifetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hBFC00000;
`ifdef IFQ_BYPASS_EN
    localparam logic        BYP_EN = 1'b1;
`else
    localparam logic        BYP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    ifetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_ready_i (inst_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] addr0;
        logic [31:0] addr1;
    } vec_t;

    // Reference model: decoded-queue contents, credit counters, and the memory's pending requests.
    ent_t        mq[$];
    logic [31:0] pending[$];
    logic [31:0] delivered[$];
    int          m_out;
    int          m_disc;
    logic [31:0] m_fetch;
    int          rv_mode;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic        c_req, c_issue, c_valid;
    logic [31:0] c_addr, c_pc;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A50F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        redirect_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        inst_ready_i = 1'b0;
        #2;
        check_bit("rst_valid", inst_valid_o, 1'b0);
        check_bit("rst_req", mem_req_o, 1'b0);
        mq.delete();
        pending.delete();
        m_out   = 0;
        m_disc  = 0;
        m_fetch = RPC;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock cycle: drive memory response, check outputs at negedge, advance the model.
    task automatic cycle();
        logic        byp, exp_req, exp_valid, issue;
        int          resp;
        logic [31:0] raddr;
        ent_t        head;
        ent_t        e;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        if (pending.size() > 0 &&
            (rv_mode == 1 || (rv_mode == 2 && $urandom_range(0, 99) < 60))) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memdata(pending[0]);
        end
        @(negedge clk);
        exp_req = ((mq.size() + m_out) < DEPTH) && !redirect_i;
        byp = BYP_EN && mem_rvalid_i && (m_disc == 0) && (mq.size() == 0)
              && inst_ready_i && !redirect_i;
        exp_valid = ((mq.size() > 0) && !redirect_i) || byp;
        check_bit("mem_req", mem_req_o, exp_req);
        if (exp_req && mem_req_o) check("mem_addr", mem_addr_o, {m_fetch[31:2], 2'b00});
        check_bit("inst_valid", inst_valid_o, exp_valid);
        if (exp_valid && inst_valid_o) begin
            if (byp) begin
                head.pc   = pending[0];
                head.data = mem_rdata_i;
            end else begin
                head = mq[0];
            end
            check("inst_pc", inst_pc_o, head.pc);
            check("inst", inst_o, head.data);
        end
        c_req   = mem_req_o;
        c_addr  = mem_addr_o;
        c_issue = mem_req_o && mem_gnt_i;
        c_valid = inst_valid_o;
        c_pc    = inst_pc_o;
        if (inst_valid_o && inst_ready_i) delivered.push_back(inst_pc_o);

        resp  = mem_rvalid_i ? 1 : 0;
        raddr = 32'h0;
        if (resp != 0) raddr = pending.pop_front();
        if (mem_req_o && mem_gnt_i) pending.push_back(mem_addr_o);

        issue = exp_req && mem_gnt_i;
        if (redirect_i) begin
            m_fetch = redirect_pc_i;
            mq.delete();
            m_disc = m_out - resp;
            m_out  = m_out - resp;
        end else begin
            if (exp_valid && inst_ready_i && !byp) void'(mq.pop_front());
            if (resp != 0) begin
                if (m_disc > 0) m_disc--;
                else if (!byp && mq.size() < DEPTH) begin
                    e.pc   = raddr;
                    e.data = memdata(raddr);
                    mq.push_back(e);
                end
            end
            if (issue) m_fetch = m_fetch + 32'd4;
            m_out = m_out + (issue ? 1 : 0) - resp;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[6];
        int   n_iss;

        rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; inst_ready_i = 1'b0; rv_mode = 0;
        #1;
        do_reset();

        // Redirect target alignment and wrap on increment.
        tbl[0] = '{32'h00001002, 32'h00001000, 32'h00001004};
        tbl[1] = '{32'h00001003, 32'h00001000, 32'h00001004};
        tbl[2] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000000};
        tbl[3] = '{32'hFFFFFFFE, 32'hFFFFFFFC, 32'h00000000};
        tbl[4] = '{32'h00000004, 32'h00000004, 32'h00000008};
        tbl[5] = '{32'h12345679, 32'h12345678, 32'h1234567C};
        rv_mode = 1;
        inst_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            redirect_i = 1'b1; redirect_pc_i = tbl[i].rpc; mem_gnt_i = 1'b1;
            cycle();
            check_bit("tbl_req_in_redirect", c_req, 1'b0);
            redirect_i = 1'b0;
            cycle();
            check_bit("tbl_issue", c_issue, 1'b1);
            check("tbl_addr0", c_addr, tbl[i].addr0);
            mem_gnt_i = 1'b0;
            cycle();
            check("tbl_addr1", c_addr, tbl[i].addr1);
        end

        // Back-to-back fetch from reset.
        do_reset();
        mem_gnt_i = 1'b1; inst_ready_i = 1'b1; rv_mode = 1;
        delivered.delete();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_bit("seq_issue", c_issue, 1'b1);
            check("seq_addr", c_addr, RPC + 32'(4 * i));
        end
        for (int i = 0; i < 4; i++) cycle();
        check_bit("seq_delivered3", delivered.size() >= 3, 1'b1);
        if (delivered.size() >= 3)
            for (int i = 0; i < 3; i++) check("seq_pc_order", delivered[i], RPC + 32'(4 * i));

        // Decode stalled: credit limits requests to DEPTH.
        do_reset();
        mem_gnt_i = 1'b1; inst_ready_i = 1'b0; rv_mode = 1;
        n_iss = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (c_issue) n_iss++;
        end
        check("full_issue_count", 32'(n_iss), 32'(DEPTH));
        check_bit("full_req_low", c_req, 1'b0);
        check_bit("full_valid", c_valid, 1'b1);
        inst_ready_i = 1'b1; mem_gnt_i = 1'b0;
        delivered.delete();
        for (int i = 0; i < 6; i++) cycle();
        check("full_drain_count", 32'(delivered.size()), 32'(DEPTH));
        if (delivered.size() == DEPTH)
            for (int i = 0; i < DEPTH; i++) check("full_drain_pc", delivered[i], RPC + 32'(4 * i));

        // Redirect with two requests outstanding and one entry queued.
        do_reset();
        mem_gnt_i = 1'b1; inst_ready_i = 1'b0; rv_mode = 1;
        cycle();
        cycle();
        rv_mode = 0;
        cycle();
        redirect_i = 1'b1; redirect_pc_i = 32'h00001000;
        cycle();
        check_bit("redir_valid_low", c_valid, 1'b0);
        check_bit("redir_no_issue", c_issue, 1'b0);
        redirect_i = 1'b0; inst_ready_i = 1'b1; rv_mode = 1;
        delivered.delete();
        cycle();
        check_bit("redir_first_issue", c_issue, 1'b1);
        check("redir_first_addr", c_addr, 32'h00001000);
        for (int i = 0; i < 6; i++) cycle();
        check_bit("redir_delivered", delivered.size() >= 2, 1'b1);
        if (delivered.size() >= 2) begin
            check("redir_pc0", delivered[0], 32'h00001000);
            check("redir_pc1", delivered[1], 32'h00001004);
        end

        // Reset mid-stream with three entries queued.
        do_reset();
        mem_gnt_i = 1'b1; inst_ready_i = 1'b0; rv_mode = 1;
        for (int i = 0; i < 4; i++) cycle();
        check_bit("midrst_pre_valid", c_valid, 1'b1);
        do_reset();
        mem_gnt_i = 1'b1; inst_ready_i = 1'b1; rv_mode = 1;
        delivered.delete();
        cycle();
        check_bit("midrst_issue", c_issue, 1'b1);
        check("midrst_addr", c_addr, RPC);
        cycle();
        check_bit("midrst_resp_cycle_valid", c_valid, BYP_EN);
        cycle();
        check_bit("midrst_valid_next", c_valid, 1'b1);
        check_bit("midrst_delivered", delivered.size() >= 1, 1'b1);
        if (delivered.size() >= 1) check("midrst_pc0", delivered[0], RPC);

        // Random traffic against the model.
        do_reset();
        rv_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            redirect_i = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0) redirect_pc_i = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            else redirect_pc_i = $urandom();
            mem_gnt_i    = ($urandom_range(0, 99) < 70);
            inst_ready_i = ($urandom_range(0, 99) < 70);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
